// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide issue sequencers.
// Holds the state encoding and the default watchdog limit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/multdiv_issue_operand_check.sv
// Combinational operand screening: flags a multiplier that does not fit
// 16-bit signed, and a zero operand that makes the core's sign check meaningless.
module operand_check (
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        range_err,
  output logic        zero
);

  // B fits 16-bit signed only when bits 31..15 are a pure sign extension
  assign range_err = ~((&operand_b[31:15]) | ~(|operand_b[31:15]));
  assign zero      = (operand_a == 32'd0) | (operand_b == 32'd0);

endmodule

// File: rtl/multdiv_issue.sv
// Issue sequencer between the execute stage and the 32x16 Booth multiplier core:
// latches operands, runs the core, and returns a one-cycle write-back.
module multdiv_issue
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic [4:0]  ctrl_rd,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception,
  output logic [31:0] mult_operandA,
  output logic [15:0] mult_operandB,
  output logic        mult_ctrl,
  input  logic [31:0] mult_result,
  input  logic        mult_exception,
  input  logic        mult_resultRDY
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t          state;
  state_t          next_state;
  logic [WD_W-1:0] watchdog;
  logic [31:0]     op_a;
  logic [15:0]     op_b;
  logic [4:0]      op_rd;
  logic            op_range;
  logic            op_zero;
  logic            range_err;
  logic            zero;
  logic            accept;
  logic            capture;
  logic            timeout;

  operand_check u_operand_check (
    .operand_a (data_operandA),
    .operand_b (data_operandB),
    .range_err (range_err),
    .zero      (zero)
  );

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_MULT) begin
          next_state = BUSY;
          accept     = 1'b1;
        end
      end
      BUSY: begin
        // A ready result on the final watchdog cycle still beats the timeout
        if (mult_resultRDY) begin
          next_state = DONE;
          capture    = 1'b1;
        end else if (watchdog == WD_LAST) begin
          next_state = DONE;
          timeout    = 1'b1;
        end
      end
      DONE: begin
        if (ctrl_MULT) begin
          next_state = BUSY;
          accept     = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      watchdog     <= '0;
      op_a         <= '0;
      op_b         <= '0;
      op_rd        <= '0;
      op_range     <= 1'b0;
      op_zero      <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_exception <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        watchdog <= '0;
        op_a     <= data_operandA;
        op_b     <= data_operandB[15:0];
        op_rd    <= ctrl_rd;
        op_range <= range_err;
        op_zero  <= zero;
      end else if (state == BUSY) begin
        watchdog <= watchdog + 1'b1;
      end
      // Zero operands mask the core's spurious sign-mismatch flag
      if (capture) begin
        wb_rd        <= op_rd;
        wb_data      <= mult_result;
        wb_exception <= op_range | (mult_exception & ~op_zero);
      end else if (timeout) begin
        wb_rd        <= op_rd;
        wb_data      <= '0;
        wb_exception <= 1'b1;
      end
    end
  end

  assign mult_ctrl     = (state == BUSY);
  assign stall         = (state == BUSY) | (ctrl_MULT & (state != BUSY));
  assign wb_valid      = (state == DONE);
  assign mult_operandA = op_a;
  assign mult_operandB = op_b;

endmodule

// File: tb/tb_multdiv_issue.sv
// Self-checking bench for multdiv_issue with a behavioural multiplier core model
// and a spec-level reference for write-back data and exception.
module tb_multdiv_issue;

  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [4:0]  ctrl_rd;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;
  logic [31:0] mult_operandA;
  logic [15:0] mult_operandB;
  logic        mult_ctrl;
  logic [31:0] mult_result;
  logic        mult_exception;
  logic        mult_resultRDY;

  int checks = 0;
  int passed = 0;

  int core_cnt = 0;
  int rdy_at = 7;
  bit force_rdy = 1'b0;

  always #5 clock = ~clock;

  multdiv_issue #(.TIMEOUT(TIMEOUT)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_rd        (ctrl_rd),
    .stall          (stall),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .wb_exception   (wb_exception),
    .mult_operandA  (mult_operandA),
    .mult_operandB  (mult_operandB),
    .mult_ctrl      (mult_ctrl),
    .mult_result    (mult_result),
    .mult_exception (mult_exception),
    .mult_resultRDY (mult_resultRDY)
  );

  function automatic logic [31:0] core_product(input logic [31:0] a, input logic [15:0] b);
    longint p;
    p = longint'(signed'(a)) * longint'(signed'(b));
    return p[31:0];
  endfunction

  function automatic logic core_sign_mismatch(input logic [31:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = core_product(a, b);
    return (a[31] ^ b[15]) != p[31];
  endfunction

  // Core model: counter clears while mult_ctrl is low, ready on a chosen BUSY cycle
  always @(posedge clock) begin
    if (!mult_ctrl) core_cnt <= 0;
    else            core_cnt <= core_cnt + 1;
  end

  assign mult_result    = core_product(mult_operandA, mult_operandB);
  assign mult_exception = core_sign_mismatch(mult_operandA, mult_operandB);
  assign mult_resultRDY = force_rdy || (mult_ctrl && core_cnt == rdy_at);

  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] data, output logic exc);
    longint sb;
    bit range_bad, is_zero;
    sb        = longint'(signed'(b));
    range_bad = (sb < -32768) || (sb > 32767);
    is_zero   = (a == 0) || (b == 0);
    data      = core_product(a, b[15:0]);
    exc       = range_bad || (core_sign_mismatch(a, b[15:0]) && !is_zero);
  endfunction

  // Issues one request from the current cycle and returns in the DONE cycle
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        output int cycles, output bit stall_ok, output bit hold_ok);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    ctrl_rd       = rd;
    #1;
    stall_ok = (stall === 1'b1);
    hold_ok  = 1'b1;
    @(posedge clock); #1;
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    ctrl_rd       = 5'($urandom);
    cycles = 1;
    while (wb_valid !== 1'b1 && cycles < 40) begin
      if (stall !== 1'b1) stall_ok = 1'b0;
      if (mult_operandA !== a || mult_operandB !== b[15:0] || mult_ctrl !== 1'b1) hold_ok = 1'b0;
      @(posedge clock); #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; ctrl_MULT = 1'b0; data_operandA = '0; data_operandB = '0; ctrl_rd = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({stall, wb_valid, wb_rd, wb_data, wb_exception, mult_operandA, mult_operandB, mult_ctrl} !== '0)
      $display("[TB] FAIL reset_outputs: got stall=%b wbv=%b rd=%h data=%h exc=%b opA=%h opB=%h ctrl=%b, required all 0",
               stall, wb_valid, wb_rd, wb_data, wb_exception, mult_operandA, mult_operandB, mult_ctrl);
    else passed++;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_directed;
    logic [31:0] a_v [5] = '{32'd3, 32'hFFFFFFF9, 32'd2, 32'd2, 32'd0};
    logic [31:0] b_v [5] = '{32'd5, 32'd6, 32'h00010000, 32'hFFFF8000, 32'hFFFFFFFB};
    logic [4:0]  r_v [5] = '{5'd7, 5'd12, 5'd3, 5'd30, 5'd1};
    logic [31:0] d_v [5] = '{32'd15, 32'hFFFFFFD6, 32'd0, 32'hFFFF0000, 32'd0};
    logic        e_v [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int cycles;
    bit stall_ok, hold_ok;
    for (int i = 0; i < 5; i++) begin
      run_op(a_v[i], b_v[i], r_v[i], cycles, stall_ok, hold_ok);
      checks++;
      if (cycles != 9) $display("[TB] FAIL dir%0d_latency: got %0d cycles, required 9", i, cycles);
      else passed++;
      checks++;
      if (!stall_ok || !hold_ok) $display("[TB] FAIL dir%0d_stall_hold: got stall_ok=%b hold_ok=%b, required 1/1", i, stall_ok, hold_ok);
      else passed++;
      checks++;
      if (wb_rd !== r_v[i] || wb_data !== d_v[i] || wb_exception !== e_v[i])
        $display("[TB] FAIL dir%0d_wb: got rd=%0d data=%h exc=%b, required rd=%0d data=%h exc=%b",
                 i, wb_rd, wb_data, wb_exception, r_v[i], d_v[i], e_v[i]);
      else passed++;
      checks++;
      if (stall !== 1'b0) $display("[TB] FAIL dir%0d_done_stall: got %b, required 0", i, stall);
      else passed++;
      @(posedge clock); #1;
      checks++;
      if (wb_valid !== 1'b0 || wb_data !== d_v[i]) $display("[TB] FAIL dir%0d_pulse_hold: got wbv=%b data=%h, required 0/%h", i, wb_valid, wb_data, d_v[i]);
      else passed++;
    end
  endtask

  task automatic test_random;
    int cycles, gap;
    bit stall_ok, hold_ok;
    logic [31:0] a, b, exp_d;
    logic [4:0] rd;
    logic exp_e;
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom;
        default: b = {{16{1'b0}}, 16'($urandom)} ^ ($urandom_range(0, 1) ? 32'hFFFF0000 : 32'd0);
      endcase
      if (b[31:16] == 16'hFFFF || b[31:16] == 16'h0000) b = 32'(signed'(b[15:0]));
      rd = 5'($urandom);
      ref_model(a, b, exp_d, exp_e);
      run_op(a, b, rd, cycles, stall_ok, hold_ok);
      checks++;
      if (cycles != 9 || !stall_ok || !hold_ok)
        $display("[TB] FAIL rnd%0d_timing: got cycles=%0d stall_ok=%b hold_ok=%b, required 9/1/1", i, cycles, stall_ok, hold_ok);
      else passed++;
      checks++;
      if (wb_rd !== rd || wb_data !== exp_d || wb_exception !== exp_e)
        $display("[TB] FAIL rnd%0d_wb a=%h b=%h: got rd=%0d data=%h exc=%b, required rd=%0d data=%h exc=%b",
                 i, a, b, wb_rd, wb_data, wb_exception, rd, exp_d, exp_e);
      else passed++;
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clock);
        #1;
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back;
    int c1, c2;
    bit s1, h1, s2, h2;
    run_op(32'd100, 32'd3, 5'd9, c1, s1, h1);
    run_op(32'hFFFFFFFE, 32'd50, 5'd10, c2, s2, h2);
    checks++;
    if (c1 != 9 || c2 != 9) $display("[TB] FAIL b2b_spacing: got %0d then %0d cycles, required 9 and 9", c1, c2);
    else passed++;
    checks++;
    if (wb_rd !== 5'd10 || wb_data !== 32'hFFFFFF9C || wb_exception !== 1'b0 || !s2 || !h2)
      $display("[TB] FAIL b2b_second: got rd=%0d data=%h exc=%b stall_ok=%b hold_ok=%b, required 10/ffffff9c/0/1/1",
               wb_rd, wb_data, wb_exception, s2, h2);
    else passed++;
    @(posedge clock); #1;
  endtask

  task automatic test_timeout;
    int cycles;
    bit stall_ok, hold_ok;
    logic [31:0] exp_d;
    logic exp_e;
    rdy_at = 1000;
    run_op(32'd11, 32'd13, 5'd21, cycles, stall_ok, hold_ok);
    checks++;
    if (cycles != TIMEOUT + 1 || wb_data !== 32'd0 || wb_exception !== 1'b1 || wb_rd !== 5'd21)
      $display("[TB] FAIL timeout: got cycles=%0d data=%h exc=%b rd=%0d, required %0d/0/1/21",
               cycles, wb_data, wb_exception, wb_rd, TIMEOUT + 1);
    else passed++;
    @(posedge clock); #1;
    rdy_at = TIMEOUT - 1;
    ref_model(32'hFFFFFFFD, 32'd9, exp_d, exp_e);
    run_op(32'hFFFFFFFD, 32'd9, 5'd22, cycles, stall_ok, hold_ok);
    checks++;
    if (cycles != TIMEOUT + 1 || wb_data !== exp_d || wb_exception !== exp_e)
      $display("[TB] FAIL rdy_vs_timeout: got cycles=%0d data=%h exc=%b, required %0d/%h/%b",
               cycles, wb_data, wb_exception, TIMEOUT + 1, exp_d, exp_e);
    else passed++;
    rdy_at = 7;
    @(posedge clock); #1;
  endtask

  task automatic test_rdy_outside_busy;
    logic [31:0] held;
    bit bad;
    held = wb_data;
    bad = 1'b0;
    force_rdy = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      if (wb_valid !== 1'b0 || stall !== 1'b0 || wb_data !== held) bad = 1'b1;
    end
    force_rdy = 1'b0;
    checks++;
    if (bad) $display("[TB] FAIL rdy_idle: got wbv=%b stall=%b data=%h, required 0/0/%h", wb_valid, stall, wb_data, held);
    else passed++;
  endtask

  task automatic test_reset_mid_busy;
    bit seen;
    ctrl_MULT = 1'b1; data_operandA = 32'd6; data_operandB = 32'd7; ctrl_rd = 5'd4;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++;
    if ({stall, wb_valid, wb_rd, wb_data, wb_exception, mult_operandA, mult_operandB, mult_ctrl} !== '0)
      $display("[TB] FAIL reset_busy_outputs: got stall=%b wbv=%b rd=%h data=%h exc=%b opA=%h opB=%h ctrl=%b, required all 0",
               stall, wb_valid, wb_rd, wb_data, wb_exception, mult_operandA, mult_operandB, mult_ctrl);
    else passed++;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clock); #1;
      if (wb_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) $display("[TB] FAIL reset_busy_no_wb: got wb_valid=1, required 0");
    else passed++;
  endtask

  initial begin
    $display("[TB] starting multdiv_issue bench");
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_timeout;
    test_rdy_outside_busy;
    test_reset_mid_busy;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
